serial_dft_corr_mc: RTL and testbench

- Multi-channel serial single-bin DFT correlator; next generation of the serial FFT core.
- Accumulates x[n]·W[(n·bin) mod N] over one frame per channel and emits one complex result per channel per frame.
- New over the previous core:
  - runtime frame length and bin select;
  - internal twiddle-address phase generator driving an external registered ROM;
  - input stalls;
  - saturation with per-channel overflow flags;
  - synchronous frame flush.
- Sits between the ADC sample framer and the amplitude/phase (AC_PH) stage.

---
 rtl/serial_dft_corr_mc.sv | 174 +++++++++++++++++
 tb/tb_serial_dft_corr_mc.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_dft_corr_mc.sv
// Multi-channel serial single-bin DFT correlator: accumulates x[n]*W[(n*k) mod N]
// per channel over one frame, with a phase-driven twiddle ROM address, saturation and flush.
module serial_dft_corr_mc #(
  parameter int W_WIDTH      = 16,
  parameter int X_WIDTH      = 16,
  parameter int S_WIDTH      = 32,
  parameter int FRAME_LENGTH = 4,
  parameter int CHANELS      = 2,
  parameter int SHIFT        = 0
) (
  input  logic                                     clk,
  input  logic                                     rstn,
  input  logic [$clog2(FRAME_LENGTH+1)-1:0]        frame_len,
  input  logic [$clog2(FRAME_LENGTH)-1:0]          bin,
  input  logic                                     clear,
  input  logic                                     valid_i,
  input  logic signed [CHANELS-1:0][X_WIDTH-1:0]   x,
  output logic [$clog2(FRAME_LENGTH)-1:0]          w_addr,
  input  logic signed [W_WIDTH-1:0]                w_re,
  input  logic signed [W_WIDTH-1:0]                w_im,
  output logic signed [CHANELS-1:0][S_WIDTH-1:0]   re,
  output logic signed [CHANELS-1:0][S_WIDTH-1:0]   im,
  output logic [CHANELS-1:0]                       ovf,
  output logic                                     valid_o,
  output logic                                     busy
);

  localparam int AW = $clog2(FRAME_LENGTH);
  localparam int LW = $clog2(FRAME_LENGTH + 1);
  localparam int PW = X_WIDTH + W_WIDTH;
  localparam int EW = ((PW > S_WIDTH) ? PW : S_WIDTH) + 1;
  localparam logic signed [EW-1:0] SMAX = {{(EW-S_WIDTH+1){1'b0}}, {(S_WIDTH-1){1'b1}}};
  localparam logic signed [EW-1:0] SMIN = {{(EW-S_WIDTH+1){1'b1}}, {(S_WIDTH-1){1'b0}}};

  logic [AW-1:0] cnt;
  logic [AW-1:0] phase;
  logic [AW-1:0] k_reg;
  logic [LW-1:0] n_reg;

  logic          accept;
  logic          start;
  logic          last;
  logic [LW-1:0] cur_n;
  logic [AW-1:0] cur_k;
  logic [LW-1:0] cnt_inc;
  logic [AW:0]   phase_sum;
  logic [AW:0]   n_ext;
  logic [AW-1:0] phase_next;

  logic                             s1_valid;
  logic                             s1_last;
  logic                             s1_first;
  logic [CHANELS-1:0][X_WIDTH-1:0]  s1_x;

  logic                             s2_last;
  logic signed [S_WIDTH-1:0]        acc_re [CHANELS];
  logic signed [S_WIDTH-1:0]        acc_im [CHANELS];
  logic signed [S_WIDTH-1:0]        nxt_re [CHANELS];
  logic signed [S_WIDTH-1:0]        nxt_im [CHANELS];
  logic [CHANELS-1:0]               hit;
  logic [CHANELS-1:0]               sticky;

  assign accept = valid_i & ~clear;
  assign start  = accept & (cnt == '0);
  assign cur_n  = start ? frame_len : n_reg;
  assign cur_k  = start ? bin : k_reg;

  // Last sample is either the N-th one or the hard wrap at FRAME_LENGTH, so illegal N cannot hang.
  assign cnt_inc = LW'(cnt) + LW'(1);
  assign last    = (cnt_inc == cur_n) | (cnt == AW'(FRAME_LENGTH - 1));

  assign phase_sum  = {1'b0, phase} + {1'b0, cur_k};
  assign n_ext      = (AW+1)'(cur_n);
  assign phase_next = AW'((phase_sum >= n_ext) ? (phase_sum - n_ext) : phase_sum);

  assign w_addr = phase;
  assign busy   = (cnt != '0) | s1_valid | s2_last;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      cnt   <= '0;
      phase <= '0;
      n_reg <= '0;
      k_reg <= '0;
    end else if (clear) begin
      cnt   <= '0;
      phase <= '0;
    end else if (valid_i) begin
      if (start) begin
        n_reg <= frame_len;
        k_reg <= bin;
      end
      cnt   <= last ? '0 : cnt + 1'b1;
      phase <= last ? '0 : phase_next;
    end
  end

  // Stage 1 lines the sample up with the registered ROM word for its address.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      s1_valid <= 1'b0;
      s1_last  <= 1'b0;
      s1_first <= 1'b0;
      s1_x     <= '0;
    end else begin
      s1_valid <= accept;
      s1_last  <= last;
      s1_first <= start;
      if (accept) s1_x <= x;
    end
  end

  for (genvar g = 0; g < CHANELS; g++) begin : g_ch
    logic signed [PW-1:0] xe, we_re, we_im, p_re, p_im;
    logic signed [EW-1:0] base_re, base_im, sum_re, sum_im;

    assign xe    = PW'($signed(s1_x[g]));
    assign we_re = PW'(w_re);
    assign we_im = PW'(w_im);
    assign p_re  = (xe * we_re) >>> SHIFT;
    assign p_im  = (xe * we_im) >>> SHIFT;

    assign base_re = s1_first ? {EW{1'b0}} : EW'(acc_re[g]);
    assign base_im = s1_first ? {EW{1'b0}} : EW'(acc_im[g]);
    assign sum_re  = base_re + EW'(p_re);
    assign sum_im  = base_im + EW'(p_im);

    assign nxt_re[g] = (sum_re > SMAX) ? SMAX[S_WIDTH-1:0] :
                       (sum_re < SMIN) ? SMIN[S_WIDTH-1:0] : sum_re[S_WIDTH-1:0];
    assign nxt_im[g] = (sum_im > SMAX) ? SMAX[S_WIDTH-1:0] :
                       (sum_im < SMIN) ? SMIN[S_WIDTH-1:0] : sum_im[S_WIDTH-1:0];
    assign hit[g]    = (sum_re > SMAX) | (sum_re < SMIN) | (sum_im > SMAX) | (sum_im < SMIN);
  end

  // The first sample of a frame loads rather than adds, so frames can run back to back.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      s2_last <= 1'b0;
      sticky  <= '0;
      for (int i = 0; i < CHANELS; i++) begin
        acc_re[i] <= '0;
        acc_im[i] <= '0;
      end
    end else begin
      s2_last <= s1_valid & s1_last & ~clear;
      if (s1_valid && !clear) begin
        for (int i = 0; i < CHANELS; i++) begin
          acc_re[i] <= nxt_re[i];
          acc_im[i] <= nxt_im[i];
          sticky[i] <= (s1_first ? 1'b0 : sticky[i]) | hit[i];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      re      <= '0;
      im      <= '0;
      ovf     <= '0;
      valid_o <= 1'b0;
    end else begin
      valid_o <= s2_last & ~clear;
      if (s2_last && !clear) begin
        for (int i = 0; i < CHANELS; i++) begin
          re[i] <= acc_re[i];
          im[i] <= acc_im[i];
        end
        ovf <= sticky;
      end
    end
  end

endmodule

// File: tb/tb_serial_dft_corr_mc.sv
// Directed bench for serial_dft_corr_mc with a registered 4-entry twiddle ROM model.
module tb_serial_dft_corr_mc;

  logic                      clk = 1'b0;
  logic                      rstn;
  logic [2:0]                frame_len;
  logic [1:0]                bin;
  logic                      clear;
  logic                      valid_i;
  logic signed [1:0][15:0]   x;
  logic [1:0]                w_addr;
  logic signed [15:0]        w_re;
  logic signed [15:0]        w_im;
  logic signed [1:0][15:0]   re;
  logic signed [1:0][15:0]   im;
  logic [1:0]                ovf;
  logic                      valid_o;
  logic                      busy;

  serial_dft_corr_mc #(
    .W_WIDTH(16), .X_WIDTH(16), .S_WIDTH(16),
    .FRAME_LENGTH(4), .CHANELS(2), .SHIFT(0)
  ) dut (
    .clk(clk), .rstn(rstn), .frame_len(frame_len), .bin(bin), .clear(clear),
    .valid_i(valid_i), .x(x), .w_addr(w_addr), .w_re(w_re), .w_im(w_im),
    .re(re), .im(im), .ovf(ovf), .valid_o(valid_o), .busy(busy)
  );

  always #5 clk = ~clk;

  logic signed [15:0] tab_re [4];
  logic signed [15:0] tab_im [4];
  logic               sat_mode;

  // Registered ROM: data for w_addr appears one cycle later.
  always @(posedge clk) begin
    w_re <= sat_mode ? 16'sd32767 : tab_re[w_addr];
    w_im <= sat_mode ? 16'sd0     : tab_im[w_addr];
  end

  typedef struct {
    int re0; int re1; int im0; int im1; int ovf; int cyc;
  } res_t;

  res_t q[$];
  int   cyc = 0;
  int   total = 0;
  int   bad = 0;
  int   last_acc = 0;
  int   xa [4];
  int   xb [4];
  int   ad [4];

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (valid_o) begin
      res_t r;
      r.re0 = int'($signed(re[0]));
      r.re1 = int'($signed(re[1]));
      r.im0 = int'($signed(im[0]));
      r.im1 = int'($signed(im[1]));
      r.ovf = int'(ovf);
      r.cyc = cyc;
      q.push_back(r);
    end
  end

  task automatic checkOutput(input string tag, input int actual, input int expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got %0d expected %0d", tag, actual, expected);
    end
  endtask

  // One clock with the given inputs; exp_addr < 0 skips the address check.
  task automatic applyStimulus(input logic v, input logic clr, input int x0, input int x1,
                               input int exp_addr);
    valid_i = v;
    clear   = clr;
    x[0]    = x0[15:0];
    x[1]    = x1[15:0];
    #1;
    if (exp_addr >= 0) checkOutput("w_addr", int'(w_addr), exp_addr);
    @(posedge clk);
    #1;
    if (v && !clr) last_acc = cyc;
    valid_i = 1'b0;
    clear   = 1'b0;
  endtask

  task automatic sendFrame(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b1, 1'b0, xa[i], xb[i], ad[i]);
  endtask

  task automatic checkResult(input string tag, input int r0, input int r1, input int i0,
                             input int i1, input int o, input int exp_cyc);
    int t = 0;
    res_t r;
    while (q.size() == 0 && t < 20) begin
      @(posedge clk);
      #1;
      t++;
    end
    if (q.size() == 0) begin
      checkOutput({tag, "_timeout"}, 0, 1);
      return;
    end
    r = q.pop_front();
    checkOutput({tag, "_re0"}, r.re0, r0);
    checkOutput({tag, "_re1"}, r.re1, r1);
    checkOutput({tag, "_im0"}, r.im0, i0);
    checkOutput({tag, "_im1"}, r.im1, i1);
    checkOutput({tag, "_ovf"}, r.ovf, o);
    checkOutput({tag, "_cyc"}, r.cyc, exp_cyc);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b0, 0, 0, -1);
  endtask

  task automatic loadBasic();
    xa = '{1, 3, 5, 7};
    xb = '{2, 4, 6, 8};
    ad = '{0, 1, 2, 3};
  endtask

  initial begin
    int l1;
    int first;
    tab_re = '{16'sd1, 16'sd0, -16'sd1, 16'sd0};
    tab_im = '{16'sd0, -16'sd1, 16'sd0, 16'sd1};
    sat_mode  = 1'b0;
    rstn      = 1'b0;
    frame_len = 3'd4;
    bin       = 2'd1;
    clear     = 1'b0;
    valid_i   = 1'b0;
    x         = '0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("rst_re0", int'($signed(re[0])), 0);
    checkOutput("rst_im1", int'($signed(im[1])), 0);
    checkOutput("rst_ovf", int'(ovf), 0);
    checkOutput("rst_valid", int'(valid_o), 0);
    checkOutput("rst_busy", int'(busy), 0);
    checkOutput("rst_waddr", int'(w_addr), 0);
    rstn = 1'b1;
    idle(2);

    // Basic frame, bin 1
    loadBasic();
    sendFrame(4);
    checkOutput("busy_inflight", int'(busy), 1);
    checkResult("basic", -4, -4, 4, 4, 0, last_acc + 2);
    checkOutput("busy_done", int'(busy), 0);
    idle(2);

    // Back-to-back frames; bin changes mid-frame only affect the next frame
    applyStimulus(1'b1, 1'b0, 1, 2, 0);
    bin = 2'd0;
    for (int i = 1; i < 4; i++) applyStimulus(1'b1, 1'b0, xa[i], xb[i], ad[i]);
    l1 = last_acc;
    ad = '{0, 0, 0, 0};
    sendFrame(4);
    checkResult("b2b1", -4, -4, 4, 4, 0, l1 + 2);
    checkResult("b2b2", 16, 20, 0, 0, 0, last_acc + 2);
    idle(2);

    // Short frame N=3, bin 2
    frame_len = 3'd3;
    bin       = 2'd2;
    xa = '{1, 1, 1, 0};
    xb = '{0, 0, 0, 0};
    ad = '{0, 2, 1, 0};
    sendFrame(3);
    checkResult("n3", 0, 0, -1, 0, 0, last_acc + 2);
    frame_len = 3'd4;
    bin       = 2'd1;
    idle(2);

    // Stall of 3 cycles between samples 2 and 3; address must hold
    loadBasic();
    applyStimulus(1'b1, 1'b0, xa[0], xb[0], 0);
    first = last_acc;
    applyStimulus(1'b1, 1'b0, xa[1], xb[1], 1);
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b0, 0, 0, 2);
    applyStimulus(1'b1, 1'b0, xa[2], xb[2], 2);
    applyStimulus(1'b1, 1'b0, xa[3], xb[3], 3);
    checkResult("gap", -4, -4, 4, 4, 0, first + 8);
    idle(2);

    // Clear after two samples, with a dropped sample in the clear cycle
    applyStimulus(1'b1, 1'b0, 50, 50, 0);
    applyStimulus(1'b1, 1'b0, 50, 50, 1);
    applyStimulus(1'b1, 1'b1, 9, 9, -1);
    checkOutput("clr_busy", int'(busy), 0);
    checkOutput("clr_waddr", int'(w_addr), 0);
    checkOutput("clr_keep_re", int'($signed(re[0])), -4);
    idle(4);
    checkOutput("clr_no_valid", q.size(), 0);
    sendFrame(4);
    checkResult("after_clr", -4, -4, 4, 4, 0, last_acc + 2);
    idle(2);

    // Saturation on ch0, then a clean frame clears the flag
    sat_mode = 1'b1;
    xa = '{32767, 32767, 32767, 32767};
    xb = '{0, 0, 0, 0};
    sendFrame(4);
    checkResult("sat", 32767, 0, 0, 0, 1, last_acc + 2);
    sat_mode = 1'b0;
    idle(1);
    loadBasic();
    sendFrame(4);
    checkResult("post_sat", -4, -4, 4, 4, 0, last_acc + 2);
    idle(2);

    // Reset in the middle of a frame
    applyStimulus(1'b1, 1'b0, 1, 2, 0);
    applyStimulus(1'b1, 1'b0, 3, 4, 1);
    rstn = 1'b0;
    applyStimulus(1'b1, 1'b0, 5, 6, -1);
    applyStimulus(1'b1, 1'b0, 7, 8, -1);
    checkOutput("mrst_re0", int'($signed(re[0])), 0);
    checkOutput("mrst_im0", int'($signed(im[0])), 0);
    checkOutput("mrst_busy", int'(busy), 0);
    checkOutput("mrst_waddr", int'(w_addr), 0);
    rstn = 1'b1;
    idle(4);
    checkOutput("mrst_no_valid", q.size(), 0);
    sendFrame(4);
    checkResult("after_rst", -4, -4, 4, 4, 0, last_acc + 2);
    idle(3);
    checkOutput("no_extra_valid", q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
